mod2011_residue_accumulator: RTL and testbench

//  Sequential modulo-2011 reducer downstream of the 6-input chunk-residue LUT stages (X_nn).

---
 rtl/mod2011_residue_accumulator_if.sv | 25 ++
 rtl/mod2011_residue_accumulator.sv | 84 ++++++++
 tb/tb_mod2011_residue_accumulator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mod2011_residue_accumulator_if.sv
// Residue stream in, reduced packet result out; both sides valid/ready.
interface mod2011_residue_accumulator_if #(
  parameter int W     = 11,
  parameter int CNT_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_err, out_count
  );
endinterface

// File: rtl/mod2011_residue_accumulator.sv
// Sums a packet of chunk residues modulo MODULUS and presents the result with valid/ready.
//   state | meaning
//   ACCUM | accepting beats, folding each into acc
//   HOLD  | result held on out_*, waiting for out_ready
module mod2011_residue_accumulator #(
  parameter int MODULUS = 2011,
  parameter int W       = 11,
  parameter int CNT_W   = 7
) (
  input logic clk,
  input logic rst,
  mod2011_residue_accumulator_if.slave bus
);
  localparam logic [W-1:0] MOD_W = W'(MODULUS);
  localparam logic [W:0]   MOD_X = (W+1)'(MODULUS);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic             err;
  logic [CNT_W-1:0] cnt;

  logic             bad;
  logic [W-1:0]     d;
  logic [W:0]       s;
  logic [W-1:0]     r;
  logic             e;
  logic [CNT_W-1:0] c;

  // Out-of-range inputs are below 2^W < 2*MODULUS, so one subtraction brings them in range.
  always_comb begin
    bad = (bus.in_data >= MOD_W);
    d   = bad ? bus.in_data - MOD_W : bus.in_data;
    s   = {1'b0, acc} + {1'b0, d};
    r   = (s >= MOD_X) ? W'(s - MOD_X) : s[W-1:0];
    e   = err | bad;
    c   = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      err           <= 1'b0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_err   <= 1'b0;
      bus.out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            if (bus.in_last) begin
              bus.out_data  <= r;
              bus.out_err   <= e;
              bus.out_count <= c;
              acc           <= '0;
              err           <= 1'b0;
              cnt           <= '0;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= HOLD;
            end else begin
              acc <= r;
              err <= e;
              cnt <= c;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_mod2011_residue_accumulator.sv
// Bench for mod2011_residue_accumulator: directed packets plus random packets vs a packet-level model.
module tb_mod2011_residue_accumulator;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   started  = 1'b0;
  bit   rand_mode = 1'b0;

  mod2011_residue_accumulator_if bus ();

  mod2011_residue_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: running integer total, reduced only when the packet closes.
  int m_total, m_cnt, m_data, m_ocnt;
  bit m_err, m_oerr, m_hold;

  always @(posedge clk or posedge rst) begin : model
    int tot;
    int n;
    bit e;
    if (rst) begin
      m_total <= 0; m_cnt <= 0; m_err <= 1'b0; m_hold <= 1'b0;
      m_data <= 0; m_oerr <= 1'b0; m_ocnt <= 0;
    end else if (!m_hold) begin
      if (bus.in_valid) begin
        tot = m_total + int'(bus.in_data);
        n   = m_cnt + 1;
        e   = m_err | (bus.in_data >= 11'd2011);
        if (bus.in_last) begin
          m_data  <= tot % 2011;
          m_oerr  <= e;
          m_ocnt  <= (n > 127) ? 127 : n;
          m_total <= 0; m_cnt <= 0; m_err <= 1'b0;
          m_hold  <= 1'b1;
        end else begin
          m_total <= tot; m_cnt <= n; m_err <= e;
        end
      end
    end else if (bus.out_ready) begin
      m_hold <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_in_ready",  int'(bus.in_ready),  int'(!m_hold));
      chk("cmp_out_valid", int'(bus.out_valid), int'(m_hold));
      chk("cmp_out_data",  int'(bus.out_data),  m_data);
      chk("cmp_out_err",   int'(bus.out_err),   int'(m_oerr));
      chk("cmp_out_count", int'(bus.out_count), m_ocnt);
    end
  end

  task automatic send(input int data, input bit last);
    bit ok;
    int n;
    n = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 11'(data);
    bus.in_last  = last;
    if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int data, input int err, input int cnt);
    @(negedge clk);
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_data"},  int'(bus.out_data),  data);
    chk({tag, "_err"},   int'(bus.out_err),   err);
    chk({tag, "_count"}, int'(bus.out_count), cnt);
  endtask

  task automatic drain();
    bit ov, rd, done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      ov = bus.out_valid;
      rd = bus.out_ready;
      @(posedge clk);
      #1;
      n++;
      if (ov && rd) done = 1'b1;
      else if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int len, v;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #22 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    chk("rst_out_count", int'(bus.out_count), 0);
    started = 1'b1;
    @(posedge clk); #1;

    // wrap to exactly the modulus
    send(2010, 0); send(1, 1);
    expect_res("t1", 0, 0, 2);
    drain();

    send(1000, 0); send(1000, 0); send(1000, 1);
    expect_res("t2", 989, 0, 3);
    drain();

    send(2047, 1);
    expect_res("t3a", 36, 1, 1);
    drain();
    send(5, 1);
    expect_res("t3b", 5, 0, 1);
    drain();

    // backpressure, with a stray beat offered during HOLD
    bus.out_ready = 1'b0;
    send(7, 0); send(9, 1);
    expect_res("t4", 16, 0, 2);
    bus.in_valid = 1'b1; bus.in_data = 11'd123; bus.in_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_data",     int'(bus.out_data),  16);
      chk("t4_hold_in_ready", int'(bus.in_ready),  0);
      chk("t4_hold_valid",    int'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_in_ready_after", int'(bus.in_ready),  1);
    chk("t4_valid_after",    int'(bus.out_valid), 0);
    chk("t4_data_kept",      int'(bus.out_data),  16);
    @(posedge clk); #1;

    // reset mid-packet discards the partial sum
    send(500, 0); send(600, 0);
    rst = 1'b1;
    #1 chk("t5_rst_valid", int'(bus.out_valid), 0);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    send(5, 0); send(6, 1);
    expect_res("t5", 11, 0, 2);
    drain();

    // reset during HOLD drops the pending result at once
    bus.out_ready = 1'b0;
    send(3, 1);
    expect_res("t5b", 3, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5b_rst_valid", int'(bus.out_valid), 0);
    chk("t5b_rst_ready", int'(bus.in_ready),  1);
    chk("t5b_rst_data",  int'(bus.out_data),  0);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    rand_mode = 1'b1;
    for (int p = 0; p < 24; p++) begin
      len = (p == 0) ? 150 : int'($urandom_range(1, 150));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        case ($urandom_range(0, 7))
          0: v = 2010;
          1: v = 2047;
          2: v = 2011;
          default: v = int'($urandom_range(0, 2047));
        endcase
        send(v, b == len - 1);
      end
      drain();
    end
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
